// File: rtl/edac_secded_scrub_ram.sv
// SECDED (extended Hamming) protected simple dual-port RAM with a background scrubber.
// Codeword bit 0 is overall parity; bits 1..N use classic Hamming positions (checks at 2**k).
module edac_secded_scrub_ram #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 4,
   parameter int unsigned CHK_WIDTH      = 7,
   parameter int unsigned SCRUB_INTERVAL = 1024,
   parameter int unsigned CNT_WIDTH      = 16
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            wen_i,
   input  logic [ADDR_WIDTH-1:0]           waddr_i,
   input  logic [DATA_WIDTH-1:0]           wdata_i,
   input  logic [DATA_WIDTH+CHK_WIDTH-1:0] winj_i,
   input  logic                            ren_i,
   input  logic [ADDR_WIDTH-1:0]           raddr_i,
   output logic [DATA_WIDTH-1:0]           rdata_o,
   output logic                            rvalid_o,
   output logic                            rsbe_o,
   output logic                            rdbe_o,
   input  logic                            scrub_en_i,
   output logic                            scrub_wrap_o,
   input  logic                            cnt_clr_i,
   output logic [CNT_WIDTH-1:0]            sbe_cnt_o,
   output logic [CNT_WIDTH-1:0]            dbe_cnt_o
);
   localparam int CW    = int'(DATA_WIDTH + CHK_WIDTH);
   localparam int Depth = 2 ** ADDR_WIDTH;
   localparam int SynW  = int'(CHK_WIDTH) - 1;
   localparam int TmrW  = $clog2(SCRUB_INTERVAL + 1);

   typedef logic [CW-1:0] cw_t;

   function automatic logic [SynW-1:0] syndrome(input cw_t c);
      logic [SynW-1:0] s;
      s = '0;
      for (int p = 1; p < CW; p++) begin
         if (c[p]) s ^= SynW'(p);
      end
      return s;
   endfunction

   // Data fills non-power-of-two positions; check bits are then set to zero the syndrome.
   function automatic cw_t encode(input logic [DATA_WIDTH-1:0] d);
      cw_t                  c;
      logic [DATA_WIDTH-1:0] d_sh;
      logic [SynW-1:0]       s;
      c    = '0;
      d_sh = d;
      for (int p = 1; p < CW; p++) begin
         if ((p & (p - 1)) != 0) begin
            c[p] = d_sh[0];
            d_sh = d_sh >> 1;
         end
      end
      s = syndrome(c);
      for (int k = 0; k < SynW; k++) c[1 << k] = s[k];
      c[0] = ^c;
      return c;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] extract(input cw_t c);
      logic [DATA_WIDTH-1:0] d;
      d = '0;
      for (int p = CW - 1; p >= 1; p--) begin
         if ((p & (p - 1)) != 0) d = {d[DATA_WIDTH-2:0], c[p]};
      end
      return d;
   endfunction

   cw_t                   mem_q [Depth];
   cw_t                   rd_cw_q;
   logic                  s1_valid_q, s1_valid_d;
   logic                  s1_scrub_q, s1_scrub_d;
   logic                  s1_cancel_q, s1_cancel_d;
   logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
   logic                  wb_valid_q, wb_valid_d;
   logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
   cw_t                   wb_cw_q, wb_cw_d;
   logic [TmrW-1:0]       tmr_q, tmr_d;
   logic [ADDR_WIDTH-1:0] scrub_addr_q, scrub_addr_d;
   logic                  wrap_q, wrap_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  rvalid_q, rvalid_d;
   logic                  rsbe_q, rsbe_d;
   logic                  rdbe_q, rdbe_d;
   logic [CNT_WIDTH-1:0]  sbe_cnt_q, sbe_cnt_d;
   logic [CNT_WIDTH-1:0]  dbe_cnt_q, dbe_cnt_d;

   logic                  scrub_go, rd_en, sbe, dbe, wb_fire, wb_kill, wb_load;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [SynW-1:0]       syn;
   cw_t                   fixed;

   always_comb begin
      scrub_go = scrub_en_i && (tmr_q == TmrW'(SCRUB_INTERVAL)) && !ren_i &&
                 !(s1_valid_q && s1_scrub_q) && !wb_valid_q;
      rd_en    = ren_i || scrub_go;
      rd_addr  = ren_i ? raddr_i : scrub_addr_q;

      syn   = syndrome(rd_cw_q);
      fixed = rd_cw_q;
      sbe   = 1'b0;
      dbe   = 1'b0;
      if (^rd_cw_q) begin
         // Odd-weight error: correctable only if the syndrome names a real position.
         if (int'(syn) < CW) begin
            sbe   = 1'b1;
            fixed = rd_cw_q ^ (cw_t'(1) << syn);
         end else begin
            dbe = 1'b1;
         end
      end else if (syn != '0) begin
         dbe = 1'b1;
      end

      wb_fire = wb_valid_q && !wen_i;
      wb_kill = wb_valid_q && wen_i && (waddr_i == wb_addr_q);
      wb_load = s1_valid_q && sbe && !s1_cancel_q && !(wen_i && (waddr_i == s1_addr_q)) &&
                (!wb_valid_q || wb_fire || wb_kill);

      s1_valid_d  = rd_en;
      s1_scrub_d  = !ren_i;
      s1_addr_d   = rd_addr;
      s1_cancel_d = wen_i && (waddr_i == rd_addr);

      wb_valid_d = wb_valid_q;
      wb_addr_d  = wb_addr_q;
      wb_cw_d    = wb_cw_q;
      if (wb_load) begin
         wb_valid_d = 1'b1;
         wb_addr_d  = s1_addr_q;
         wb_cw_d    = fixed;
      end else if (wb_fire || wb_kill) begin
         wb_valid_d = 1'b0;
      end

      rvalid_d = s1_valid_q && !s1_scrub_q;
      rsbe_d   = rvalid_d && sbe;
      rdbe_d   = rvalid_d && dbe;
      rdata_d  = rvalid_d ? extract(fixed) : rdata_q;

      sbe_cnt_d = sbe_cnt_q;
      dbe_cnt_d = dbe_cnt_q;
      if (cnt_clr_i) begin
         sbe_cnt_d = '0;
         dbe_cnt_d = '0;
      end else if (s1_valid_q) begin
         if (sbe && (sbe_cnt_q != '1)) sbe_cnt_d = sbe_cnt_q + 1'b1;
         if (dbe && (dbe_cnt_q != '1)) dbe_cnt_d = dbe_cnt_q + 1'b1;
      end

      tmr_d = tmr_q;
      if (scrub_go) begin
         tmr_d = '0;
      end else if (scrub_en_i && (tmr_q != TmrW'(SCRUB_INTERVAL))) begin
         tmr_d = tmr_q + 1'b1;
      end
      scrub_addr_d = scrub_go ? scrub_addr_q + 1'b1 : scrub_addr_q;
      wrap_d       = scrub_go && (scrub_addr_q == '1);
   end

   always_ff @(posedge clk_i) begin
      if (wen_i) begin
         mem_q[waddr_i] <= encode(wdata_i) ^ winj_i;
      end else if (wb_fire) begin
         mem_q[wb_addr_q] <= wb_cw_q;
      end
      rd_cw_q <= mem_q[rd_addr];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid_q   <= 1'b0;
         s1_scrub_q   <= 1'b0;
         s1_cancel_q  <= 1'b0;
         s1_addr_q    <= '0;
         wb_valid_q   <= 1'b0;
         wb_addr_q    <= '0;
         wb_cw_q      <= '0;
         tmr_q        <= '0;
         scrub_addr_q <= '0;
         wrap_q       <= 1'b0;
         rdata_q      <= '0;
         rvalid_q     <= 1'b0;
         rsbe_q       <= 1'b0;
         rdbe_q       <= 1'b0;
         sbe_cnt_q    <= '0;
         dbe_cnt_q    <= '0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_scrub_q   <= s1_scrub_d;
         s1_cancel_q  <= s1_cancel_d;
         s1_addr_q    <= s1_addr_d;
         wb_valid_q   <= wb_valid_d;
         wb_addr_q    <= wb_addr_d;
         wb_cw_q      <= wb_cw_d;
         tmr_q        <= tmr_d;
         scrub_addr_q <= scrub_addr_d;
         wrap_q       <= wrap_d;
         rdata_q      <= rdata_d;
         rvalid_q     <= rvalid_d;
         rsbe_q       <= rsbe_d;
         rdbe_q       <= rdbe_d;
         sbe_cnt_q    <= sbe_cnt_d;
         dbe_cnt_q    <= dbe_cnt_d;
      end
   end

   assign rdata_o      = rdata_q;
   assign rvalid_o     = rvalid_q;
   assign rsbe_o       = rsbe_q;
   assign rdbe_o       = rdbe_q;
   assign scrub_wrap_o = wrap_q;
   assign sbe_cnt_o    = sbe_cnt_q;
   assign dbe_cnt_o    = dbe_cnt_q;

endmodule
